// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the dual-port memory arbiter: default widths, port indices
// and the low-memory window used by the monitor's bulk load/dump.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 13;
  localparam int DATA_WIDTH_DEFAULT = 8;

  localparam int PORT_MON = 0;
  localparam int PORT_CPU = 1;

  localparam logic [12:0] LOWMEM_BASE = 13'h0000;
  localparam int          LOWMEM_SIZE = 256;

  // Last-grant pointer; reset value PTR_CPU lets the monitor win the first contention.
  typedef enum logic {
    PTR_MON = 1'b0,
    PTR_CPU = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin decision with a monitor lock that holds off the cpu port
// while the monitor owns the pointer.
module rr_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  port_e      last,
  input  logic       lock,
  output logic [1:0] select
);

  logic cpu_blocked;

  assign cpu_blocked = lock && (last == PTR_MON);

  always_comb begin
    select = 2'b00;
    if (eligible[PORT_MON] && eligible[PORT_CPU]) begin
      // Under lock the monitor keeps ownership even when it was granted last.
      if ((last == PTR_CPU) || cpu_blocked) begin
        select[PORT_MON] = 1'b1;
      end else begin
        select[PORT_CPU] = 1'b1;
      end
    end else if (eligible[PORT_MON]) begin
      select[PORT_MON] = 1'b1;
    end else if (eligible[PORT_CPU] && !cpu_blocked) begin
      select[PORT_CPU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a monitor port and a cpu port onto one single-port-per-direction RAM.
// Handshake: a requester holds req/we/addr/wdata until it sees its one-cycle gnt; reads return rvalid two cycles after acceptance.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic [1:0]            eligible;
  logic [1:0]            select;
  logic [1:0]            rd_pend;
  port_e                 last;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  // A port whose gnt is showing is still holding the old request, so it sits out.
  assign eligible = {req1 & ~gnt1, req0 & ~gnt0};

  rr_arbiter u_rr (
    .eligible (eligible),
    .last     (last),
    .lock     (lock0),
    .select   (select)
  );

  always_comb begin
    acc_we    = we0;
    acc_addr  = addr0;
    acc_wdata = wdata0;
    if (select[PORT_CPU]) begin
      acc_we    = we1;
      acc_addr  = addr1;
      acc_wdata = wdata1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rd_pend   <= 2'b00;
      ram_write <= 1'b0;
      ram_waddr <= '0;
      ram_raddr <= '0;
      ram_din   <= '0;
      last      <= PTR_CPU;
    end else begin
      gnt0      <= select[PORT_MON];
      gnt1      <= select[PORT_CPU];
      ram_write <= (|select) & acc_we;
      rd_pend   <= select & {2{~acc_we}};
      // RAM read data lands one cycle after ram_raddr, aligned with rvalid.
      rvalid0   <= rd_pend[PORT_MON];
      rvalid1   <= rd_pend[PORT_CPU];
      if (|select) begin
        last <= select[PORT_CPU] ? PTR_CPU : PTR_MON;
        if (acc_we) begin
          ram_waddr <= acc_addr;
          ram_din   <= acc_wdata;
        end else begin
          ram_raddr <= acc_addr;
        end
      end
    end
  end

  assign rdata = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, per-port transaction queues, cycle-level
// reference model with an expected read-data queue, scenario tasks and a report.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = ADDR_WIDTH_DEFAULT;
  localparam int DW = DATA_WIDTH_DEFAULT;
  localparam int POOL = LOWMEM_SIZE / 8;
  localparam logic [AW-1:0] HIGH_BASE = 13'h1FE0;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  logic          req0, req1, we0, we1, lock0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_write;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_waddr, ram_raddr;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_write(ram_write), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM with registered read and a preload port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  always @(posedge CLK) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (ram_write) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  // ---------------- model state ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          txq0[$], txq1[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  int            exp_due[$], exp_port[$];
  int            gl_cyc[$], gl_port[$];       // observed grants
  int            rv_cyc[$], rv_port[$];       // observed rvalids
  logic [DW-1:0] rv_data[$];
  logic [AW-1:0] wr_addr[$];                  // observed RAM writes
  logic [DW-1:0] wr_data[$];

  int cyc = 0, vectors = 0, miscompares = 0, lock_until = 0;
  logic          m_gnt0, m_gnt1, m_write;
  int            m_last;
  logic [AW-1:0] m_raddr, m_waddr;
  logic [DW-1:0] m_din;

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    req0   = txq0.size() > 0;
    req1   = txq1.size() > 0;
    we0    = req0 ? txq0[0].we   : 1'($urandom_range(0, 1));
    addr0  = req0 ? txq0[0].addr : AW'($urandom);
    wdata0 = req0 ? txq0[0].data : DW'($urandom);
    we1    = req1 ? txq1[0].we   : 1'($urandom_range(0, 1));
    addr1  = req1 ? txq1[0].addr : AW'($urandom);
    wdata1 = req1 ? txq1[0].data : DW'($urandom);
    lock0  = cyc < lock_until;
  endtask

  function automatic logic [AW-1:0] pool_addr();
    if ($urandom_range(0, 1) == 0) return LOWMEM_BASE + AW'($urandom_range(0, POOL - 1));
    return HIGH_BASE + AW'($urandom_range(0, POOL - 1));
  endfunction

  function automatic txn_t rd_txn(logic [AW-1:0] a);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.data = '0;
    return t;
  endfunction

  function automatic txn_t wr_txn(logic [AW-1:0] a, logic [DW-1:0] d);
    txn_t t;
    t.we = 1'b1; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic clear_logs();
    gl_cyc.delete(); gl_port.delete();
    rv_cyc.delete(); rv_port.delete(); rv_data.delete();
    wr_addr.delete(); wr_data.delete();
  endtask

  // One clock: decide acceptance from the rules, advance, then score the DUT.
  task automatic step();
    int   pick;
    txn_t t;
    logic e0, e1, blk, x_rv0, x_rv1;
    logic [DW-1:0] x_rdata;
    drive_inputs();
    e0  = req0 && !m_gnt0;
    e1  = req1 && !m_gnt1;
    blk = lock0 && (m_last == PORT_MON);
    pick = -1;
    if (e0 && e1) pick = (blk || m_last == PORT_CPU) ? PORT_MON : PORT_CPU;
    else if (e0) pick = PORT_MON;
    else if (e1 && !blk) pick = PORT_CPU;
    @(posedge CLK); #1; cyc++;
    m_gnt0  = (pick == PORT_MON);
    m_gnt1  = (pick == PORT_CPU);
    m_write = 1'b0;
    if (pick >= 0) begin
      if (pick == PORT_MON) t = txq0.pop_front(); else t = txq1.pop_front();
      m_last = pick;
      if (t.we) begin
        m_write = 1'b1; m_waddr = t.addr; m_din = t.data;
        ref_mem[t.addr] = t.data;
      end else begin
        m_raddr = t.addr;
        exp_q.push_back(ref_mem[t.addr]);
        exp_due.push_back(cyc + 1);
        exp_port.push_back(pick);
      end
    end
    x_rv0 = 1'b0; x_rv1 = 1'b0; x_rdata = '0;
    if (exp_q.size() > 0 && exp_due[0] == cyc) begin
      x_rdata = exp_q.pop_front();
      void'(exp_due.pop_front());
      if (exp_port.pop_front() == PORT_MON) x_rv0 = 1'b1; else x_rv1 = 1'b1;
    end
    if (gnt0) begin gl_cyc.push_back(cyc); gl_port.push_back(0); end
    if (gnt1) begin gl_cyc.push_back(cyc); gl_port.push_back(1); end
    if (rvalid0) begin rv_cyc.push_back(cyc); rv_port.push_back(0); rv_data.push_back(rdata); end
    if (rvalid1) begin rv_cyc.push_back(cyc); rv_port.push_back(1); rv_data.push_back(rdata); end
    if (ram_write) begin wr_addr.push_back(ram_waddr); wr_data.push_back(ram_din); end
    vectors += 8;
    if (gnt0 !== m_gnt0) begin miscompares++; $display("FAIL gnt0 cyc=%0d got=%b exp=%b", cyc, gnt0, m_gnt0); end
    if (gnt1 !== m_gnt1) begin miscompares++; $display("FAIL gnt1 cyc=%0d got=%b exp=%b", cyc, gnt1, m_gnt1); end
    if (ram_write !== m_write) begin miscompares++; $display("FAIL ram_write cyc=%0d got=%b exp=%b", cyc, ram_write, m_write); end
    if (ram_waddr !== m_waddr) begin miscompares++; $display("FAIL ram_waddr cyc=%0d got=%h exp=%h", cyc, ram_waddr, m_waddr); end
    if (ram_din !== m_din) begin miscompares++; $display("FAIL ram_din cyc=%0d got=%h exp=%h", cyc, ram_din, m_din); end
    if (ram_raddr !== m_raddr) begin miscompares++; $display("FAIL ram_raddr cyc=%0d got=%h exp=%h", cyc, ram_raddr, m_raddr); end
    if (rvalid0 !== x_rv0) begin miscompares++; $display("FAIL rvalid0 cyc=%0d got=%b exp=%b", cyc, rvalid0, x_rv0); end
    if (rvalid1 !== x_rv1) begin miscompares++; $display("FAIL rvalid1 cyc=%0d got=%b exp=%b", cyc, rvalid1, x_rv1); end
    if (x_rv0 || x_rv1) begin
      vectors++;
      if (rdata !== x_rdata) begin miscompares++; $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, x_rdata); end
    end
  endtask

  task automatic run_idle(int budget, string name);
    int n = 0;
    while ((txq0.size() + txq1.size() + exp_q.size()) > 0 && n < budget) begin
      step(); n++;
    end
    vectors++;
    if ((txq0.size() + txq1.size() + exp_q.size()) != 0) begin
      miscompares++;
      $display("FAIL %s_timeout pending=%0d exp=0", name, txq0.size() + txq1.size() + exp_q.size());
      txq0.delete(); txq1.delete(); exp_q.delete(); exp_due.delete(); exp_port.delete();
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge CLK); #1; cyc++;
    rst = 1'b0;
    m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_write = 1'b0; m_last = PORT_CPU;
    m_raddr = '0; m_waddr = '0; m_din = '0;
    exp_q.delete(); exp_due.delete(); exp_port.delete();
  endtask

  task automatic check_all_zero(string name);
    vectors += 8;
    if (gnt0 !== 1'b0)    begin miscompares++; $display("FAIL %s_gnt0 got=%b exp=0", name, gnt0); end
    if (gnt1 !== 1'b0)    begin miscompares++; $display("FAIL %s_gnt1 got=%b exp=0", name, gnt1); end
    if (rvalid0 !== 1'b0) begin miscompares++; $display("FAIL %s_rvalid0 got=%b exp=0", name, rvalid0); end
    if (rvalid1 !== 1'b0) begin miscompares++; $display("FAIL %s_rvalid1 got=%b exp=0", name, rvalid1); end
    if (ram_write !== 1'b0) begin miscompares++; $display("FAIL %s_ram_write got=%b exp=0", name, ram_write); end
    if (ram_raddr !== '0) begin miscompares++; $display("FAIL %s_ram_raddr got=%h exp=0", name, ram_raddr); end
    if (ram_waddr !== '0) begin miscompares++; $display("FAIL %s_ram_waddr got=%h exp=0", name, ram_waddr); end
    if (ram_din !== '0)   begin miscompares++; $display("FAIL %s_ram_din got=%h exp=0", name, ram_din); end
  endtask

  // ---------------- scenarios ----------------
  task automatic preload();
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    load_en = 1'b1;
    for (int i = 0; i < 2 * POOL; i++) begin
      a = (i < POOL) ? LOWMEM_BASE + AW'(i) : HIGH_BASE + AW'(i - POOL);
      d = (a == 13'h0010) ? 8'hA5 : DW'($urandom);
      load_addr = a; load_data = d; ref_mem[a] = d;
      @(posedge CLK); #1;
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    drive_inputs();
    do_reset();
    check_all_zero("reset");
  endtask

  task automatic test_single_read();
    int base = cyc;
    clear_logs();
    txq0.push_back(rd_txn(13'h0010));
    run_idle(20, "single_read");
    vectors += 3;
    if (gl_cyc.size() != 1 || gl_cyc[0] != base + 1 || gl_port[0] != 0) begin
      miscompares++; $display("FAIL single_gnt0 count=%0d exp=1 at cyc %0d", gl_cyc.size(), base + 1);
    end
    if (rv_cyc.size() != 1 || rv_cyc[0] != base + 2 || rv_port[0] != 0) begin
      miscompares++; $display("FAIL single_rvalid0 count=%0d exp=1 at cyc %0d", rv_cyc.size(), base + 2);
    end else if (rv_data[0] !== 8'hA5) begin
      miscompares++; $display("FAIL single_rdata got=%h exp=a5", rv_data[0]);
    end
  endtask

  task automatic test_write_read();
    clear_logs();
    txq1.push_back(wr_txn(13'h1FFF, 8'h3C));
    txq1.push_back(rd_txn(13'h1FFF));
    run_idle(20, "write_read");
    vectors += 3;
    if (wr_addr.size() != 1) begin
      miscompares++; $display("FAIL wr_pulses got=%0d exp=1", wr_addr.size());
    end else if (wr_addr[0] !== 13'h1FFF || wr_data[0] !== 8'h3C) begin
      miscompares++; $display("FAIL wr_fields got=%h/%h exp=1fff/3c", wr_addr[0], wr_data[0]);
    end
    if (rv_data.size() != 1) begin
      miscompares++; $display("FAIL wr_read_count got=%0d exp=1", rv_data.size());
    end else if (rv_data[0] !== 8'h3C || rv_port[0] != 1) begin
      miscompares++; $display("FAIL wr_read_data got=%h port %0d exp=3c port 1", rv_data[0], rv_port[0]);
    end
  endtask

  task automatic test_contention();
    int base;
    do_reset();
    clear_logs();
    base = cyc;
    for (int i = 0; i < 4; i++) begin
      txq0.push_back(rd_txn(pool_addr()));
      txq1.push_back(rd_txn(pool_addr()));
    end
    run_idle(40, "contention");
    vectors++;
    if (gl_cyc.size() != 8) begin
      miscompares++; $display("FAIL cont_count got=%0d exp=8", gl_cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (gl_cyc[i] != base + 1 + i || gl_port[i] != i % 2) begin
          miscompares++;
          $display("FAIL cont_order idx=%0d got cyc %0d port %0d exp cyc %0d port %0d",
                   i, gl_cyc[i] - base, gl_port[i], i + 1, i % 2);
        end
      end
    end
  endtask

  task automatic test_lock();
    int base, first1;
    do_reset();
    clear_logs();
    base = cyc;
    lock_until = base + 7;
    for (int i = 0; i < 3; i++) txq0.push_back(rd_txn(pool_addr()));
    txq1.push_back(rd_txn(pool_addr()));
    run_idle(40, "lock");
    lock_until = 0;
    first1 = -1;
    for (int i = 0; i < gl_cyc.size(); i++) if (gl_port[i] == 1 && first1 < 0) first1 = gl_cyc[i];
    vectors += 2;
    if (first1 != base + 8) begin
      miscompares++; $display("FAIL lock_gnt1 got cyc %0d exp cyc %0d", first1 - base, 8);
    end
    if (gl_cyc.size() != 4 || gl_cyc[0] != base + 1 || gl_cyc[1] != base + 3 || gl_cyc[2] != base + 5) begin
      miscompares++; $display("FAIL lock_gnt0 grants=%0d exp 4 with port 0 at 1,3,5", gl_cyc.size());
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    txq0.push_back(rd_txn(pool_addr()));
    step();
    vectors++;
    if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL midrd_gnt0 got=%b exp=1", gnt0); end
    do_reset();
    check_all_zero("midrd");
    clear_logs();
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (rv_cyc.size() != 0) begin miscompares++; $display("FAIL midrd_rvalid got=%0d exp=0", rv_cyc.size()); end
    txq0.push_back(rd_txn(pool_addr()));
    txq1.push_back(rd_txn(pool_addr()));
    run_idle(20, "midrd");
    vectors++;
    if (gl_port.size() == 0 || gl_port[0] != 0) begin
      miscompares++; $display("FAIL midrd_winner got=%0d exp=0", gl_port.size() ? gl_port[0] : -1);
    end
  endtask

  task automatic test_held();
    clear_logs();
    for (int i = 0; i < 3; i++) txq0.push_back(rd_txn(pool_addr()));
    run_idle(20, "held");
    vectors++;
    if (gl_cyc.size() != 3) begin
      miscompares++; $display("FAIL held_count got=%0d exp=3", gl_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (gl_cyc[i] - gl_cyc[i-1] != 2) begin
          miscompares++; $display("FAIL held_spacing idx=%0d got=%0d exp=2", i, gl_cyc[i] - gl_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n0 = $urandom_range(5, 20);
      int n1 = $urandom_range(5, 20);
      for (int i = 0; i < n0; i++)
        txq0.push_back($urandom_range(0, 1) ? wr_txn(pool_addr(), DW'($urandom)) : rd_txn(pool_addr()));
      for (int i = 0; i < n1; i++)
        txq1.push_back($urandom_range(0, 1) ? wr_txn(pool_addr(), DW'($urandom)) : rd_txn(pool_addr()));
      lock_until = cyc + $urandom_range(0, 12);
      run_idle(400, "random");
      lock_until = 0;
    end
  endtask

  // ---------------- main + report ----------------
  initial begin
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    preload();
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_lock();
    test_reset_mid_read();
    test_held();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
